// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
package fetch_pkg;

    localparam int unsigned ILEN_DEFAULT = 32;
    localparam int unsigned PERF_CNT_W   = 32;

    // Sequencer state encoding
    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t S_RESET = 3'd0;
    localparam fetch_state_t S_IDLE  = 3'd1;
    localparam fetch_state_t S_REQ   = 3'd2;
    localparam fetch_state_t S_KILL  = 3'd3;
    localparam fetch_state_t S_OUT   = 3'd4;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: accepted instructions and stalled cycles.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2:0]            i_state,
    input  logic                  i_stall,
    input  logic                  i_imem_ack,
    input  logic                  i_fire,
    output logic [PERF_CNT_W-1:0] o_fetch_cnt,
    output logic [PERF_CNT_W-1:0] o_stall_cnt
);

    logic w_stall_cycle;

    // A cycle is lost when idling under stall or waiting on memory
    always_comb begin
        w_stall_cycle = ((i_state == S_IDLE) && i_stall) ||
                        (((i_state == S_REQ) || (i_state == S_KILL)) && !i_imem_ack);
    end

    // Wrapping event counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fetch_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (i_fire) begin
                o_fetch_cnt <= o_fetch_cnt + PERF_CNT_W'(1);
            end
            if (w_stall_cycle) begin
                o_stall_cnt <= o_stall_cnt + PERF_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack fetches and hands
// instructions to decode over valid/ready. Redirects squash in-flight work.
// Define FETCH_PERF_EN to add the fetch/stall performance counter outputs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       WIDTH      = 30,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
    parameter int unsigned       ILEN       = ILEN_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_redirect_valid,
    input  logic [WIDTH-1:0]      i_redirect_addr,
    output logic                  o_imem_req,
    output logic [WIDTH-1:0]      o_imem_addr,
    input  logic                  i_imem_ack,
    input  logic [ILEN-1:0]       i_imem_rdata,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [ILEN-1:0]       o_instr,
    output logic [WIDTH-1:0]      o_instr_pc,
    output logic [WIDTH-1:0]      o_pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] o_perf_fetch_cnt,
    output logic [PERF_CNT_W-1:0] o_perf_stall_cnt
`endif
);

    logic [2:0]       r_state, w_state_d;
    logic [WIDTH-1:0] r_pc, w_pc_d;
    // Address of the outstanding request; diverges from r_pc after a redirect
    logic [WIDTH-1:0] r_req_addr, w_req_addr_d;
    logic [WIDTH-1:0] r_instr_pc, w_instr_pc_d;
    logic [ILEN-1:0]  r_instr, w_instr_d;

    // Next-state and datapath updates
    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_req_addr_d = r_req_addr;
        w_instr_d    = r_instr;
        w_instr_pc_d = r_instr_pc;
        case (r_state)
            S_RESET: w_state_d = S_IDLE;
            S_IDLE: begin
                if (i_redirect_valid) w_pc_d = i_redirect_addr;
                if (!i_stall) w_state_d = S_REQ;
            end
            S_REQ: begin
                if (i_redirect_valid) begin
                    w_pc_d    = i_redirect_addr;
                    w_state_d = i_imem_ack ? S_IDLE : S_KILL;
                end else if (i_imem_ack) begin
                    w_instr_d    = i_imem_rdata;
                    w_instr_pc_d = r_pc;
                    w_pc_d       = r_pc + WIDTH'(1);
                    w_state_d    = S_OUT;
                end
            end
            S_KILL: begin
                if (i_redirect_valid) w_pc_d = i_redirect_addr;
                if (i_imem_ack) w_state_d = S_IDLE;
            end
            S_OUT: begin
                if (i_redirect_valid) begin
                    w_pc_d    = i_redirect_addr;
                    w_state_d = S_IDLE;
                end else if (i_instr_ready) begin
                    w_state_d = i_stall ? S_IDLE : S_REQ;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        // PC does not move while in S_REQ, so reloading every REQ cycle is harmless
        if (w_state_d == S_REQ) w_req_addr_d = w_pc_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_ADDR;
            r_req_addr <= RESET_ADDR;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_req_addr <= w_req_addr_d;
            r_instr    <= w_instr_d;
            r_instr_pc <= w_instr_pc_d;
        end
    end

    // Outputs come only from registers or decoded state
    always_comb begin
        o_imem_req    = (r_state == S_REQ) || (r_state == S_KILL);
        o_imem_addr   = r_req_addr;
        o_instr_valid = (r_state == S_OUT);
        o_instr       = r_instr;
        o_instr_pc    = r_instr_pc;
        o_pc_out      = r_pc;
    end

`ifdef FETCH_PERF_EN
    logic w_fire;

    // Handshake that delivers an instruction (a squash does not count)
    always_comb begin
        w_fire = (r_state == S_OUT) && i_instr_ready && !i_redirect_valid;
    end

    fetch_perf_counters u_perf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_state     (r_state),
        .i_stall     (i_stall),
        .i_imem_ack  (i_imem_ack),
        .i_fire      (w_fire),
        .o_fetch_cnt (o_perf_fetch_cnt),
        .o_stall_cnt (o_perf_stall_cnt)
    );
`endif

    // Request address must hold until the memory acknowledges
    a_imem_addr_stable: assert property (@(posedge i_clk)
        (!i_rst && o_imem_req && !i_imem_ack) |=> $stable(o_imem_addr));

    // Presented instruction must hold until decode takes it
    a_instr_stable: assert property (@(posedge i_clk)
        (!i_rst && o_instr_valid && !i_instr_ready) |=>
            ($stable(o_instr) && $stable(o_instr_pc)));

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls instruction fetch around the word-addressed program counter.
- Holds the PC register and issues req/ack fetches to instruction memory.
- Presents fetched instructions to decode through a valid/ready handshake.
- Applies redirects (branch/jump/trap) and stalls, and squashes in-flight fetches on redirect.

Parameters:
- WIDTH, 30, PC width in words (byte address = {pc, 2'b00}).
- RESET_ADDR, 0, word address loaded into PC on reset.
- ILEN, 32, instruction width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  inhibits issuing a new fetch.
- redirect_valid  input  1  redirect PC this cycle.
- redirect_addr  input  WIDTH  redirect target word address.
- imem_req  output  1  fetch request.
- imem_addr  output  WIDTH  fetch word address, stable while imem_req is high.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  ILEN  fetched instruction.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts instr.
- instr  output  ILEN  fetched instruction.
- instr_pc  output  WIDTH  word address of instr.
- pc_out  output  WIDTH  current PC register (next address to fetch).

Behaviour:
- Clocking and reset:
  - Single clock (clk).
  - rst is synchronous, active-high, and overrides everything, including mid-fetch.
  - On reset: state=S_RESET, pc=RESET_ADDR, imem_req=0, imem_addr=RESET_ADDR, instr_valid=0, instr=0, instr_pc=0.
  - An imem_ack in the reset cycle is ignored.
- Output timing: all outputs are registered or decoded from the state register only. No combinational input-to-output paths.
- States:
  - S_RESET: next goes to S_IDLE.
  - S_IDLE: imem_req=0.
    - redirect_valid loads pc=redirect_addr.
    - If stall=0, go to S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc.
    - On imem_ack with no redirect: instr=imem_rdata, instr_pc=pc, pc=pc+1 (wraps modulo 2^WIDTH), go to S_OUT. instr_valid is high the next cycle.
    - On redirect without ack: pc=redirect_addr, go to S_KILL. imem_req and imem_addr are held until ack.
    - On redirect and ack in the same cycle: data discarded, pc=redirect_addr, go to S_IDLE.
  - S_KILL: imem_req=1, imem_addr = the address of the stale request, held.
    - A further redirect overwrites pc (latest wins).
    - On imem_ack: data discarded, go to S_IDLE.
  - S_OUT: instr_valid=1; instr and instr_pc are held stable until the handshake.
    - instr_ready=1 and no redirect: instr_valid=0; go to S_REQ if stall=0, else S_IDLE.
    - redirect_valid=1: instr squashed (instr_valid=0 next cycle, not counted as consumed even if instr_ready=1), pc=redirect_addr, go to S_IDLE.
- Stall:
  - Sampled only in S_IDLE and on the S_OUT exit.
  - A request already issued always completes.
- Throughput: one instruction every 2 cycles with zero-latency ack (S_REQ and S_OUT alternating).
- Protocol checks (assertions): imem_addr stable while imem_req=1 and no ack; instr/instr_pc stable while instr_valid=1 and instr_ready=0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping on overflow.
  - perf_fetch_cnt increments on each S_OUT handshake that is not squashed.
  - perf_stall_cnt increments each cycle in S_IDLE with stall=1, and each cycle in S_REQ/S_KILL without imem_ack.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (S_RESET, S_IDLE, S_REQ, S_KILL, S_OUT).
  - Constant ILEN_DEFAULT=32.
  - Constant PERF_CNT_W=32.
- Sub-module: fetch_perf_counters, instantiated only under FETCH_PERF_EN. Inputs are state and handshake strobes; outputs are the two counters.

Test Plan:
- Reset with RESET_ADDR=0x10, ack same cycle as req, instr_ready=1 -> imem_addr 0x10,0x11,0x12 on successive requests; instr_pc matches; instr_valid every 2nd cycle.
- Ack delayed 3 cycles, redirect to 0x40 on the 2nd wait cycle -> enters S_KILL; imem_addr stays old until ack; stale data never valid; next request at 0x40.
- instr_valid=1, instr_ready=0 for 4 cycles, then redirect_valid=1 with instr_ready=1 to 0x80 -> instr held stable for 4 cycles; then squashed; next fetch at 0x80; perf_fetch_cnt unchanged.
- stall=1 for 5 cycles after a handshake -> imem_req stays 0 for those 5 cycles; fetch resumes the cycle after stall drops; perf_stall_cnt += 5.
- pc=2^WIDTH-1 fetched -> pc_out wraps to 0; next imem_addr=0.
- rst asserted while in S_REQ awaiting ack -> next cycle imem_req=0, instr_valid=0, pc_out=RESET_ADDR; late ack ignored.
